// File: rtl/regfile_write_arbiter_if.sv
// Bundle of requester handshakes, register-file write port and pending-write export
// for regfile_write_arbiter. The slave modport is the arbiter side.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]        ReqReady;
  logic                      Hold;
  logic [ADDR_W-1:0]         WriteRegister;
  logic [DATA_W-1:0]         WriteData;
  logic                      RegWrite;
  logic                      PendingValid;
  logic [ADDR_W-1:0]         PendingAddr;
  logic [ID_W-1:0]           GrantId;

  modport master (
    output ReqValid, ReqAddr, ReqData, Hold,
    input  ReqReady, WriteRegister, WriteData, RegWrite, PendingValid, PendingAddr, GrantId
  );

  modport slave (
    input  ReqValid, ReqAddr, ReqData, Hold,
    output ReqReady, WriteRegister, WriteData, RegWrite, PendingValid, PendingAddr, GrantId
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writeback sources into a one-entry register-file write stage.
// Round-robin by default; define REGARB_FIXED_PRIORITY_EN for lowest-index-wins.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 3
) (
  input logic                    Clk,
  input logic                    Rst_n,
  regfile_write_arbiter_if.slave bus
);
  logic              stage_valid;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic [ID_W-1:0]   grant_id;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic              can_accept;
  logic              handshake;
  int                base;
  int                idx;
`ifndef REGARB_FIXED_PRIORITY_EN
  logic [ID_W-1:0]   rr_ptr;
`endif

  always_comb begin
`ifdef REGARB_FIXED_PRIORITY_EN
    base = 0;
`else
    base = int'(rr_ptr);
`endif
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (base + k) % NUM_REQ;
      if (!found && bus.ReqValid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // A valid stage always drains when Hold is low, so Hold alone gates acceptance.
  assign can_accept   = Rst_n & ~bus.Hold;
  assign handshake    = found & can_accept;
  assign bus.ReqReady = handshake ? (NUM_REQ'(1) << winner) : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
      grant_id    <= '0;
    end else if (handshake) begin
      stage_valid <= 1'b1;
      stage_addr  <= bus.ReqAddr[int'(winner)*ADDR_W +: ADDR_W];
      stage_data  <= bus.ReqData[int'(winner)*DATA_W +: DATA_W];
      grant_id    <= winner;
    end else if (!bus.Hold) begin
      stage_valid <= 1'b0;
    end
  end

`ifndef REGARB_FIXED_PRIORITY_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      if (int'(winner) == NUM_REQ - 1) rr_ptr <= '0;
      else                             rr_ptr <= winner + ID_W'(1);
    end
  end
`endif

  // Register 0 writes occupy the stage but never assert the write enable.
  assign bus.RegWrite      = stage_valid & ~bus.Hold & (stage_addr != '0);
  assign bus.WriteRegister = stage_addr;
  assign bus.WriteData     = stage_data;
  assign bus.PendingValid  = stage_valid;
  assign bus.PendingAddr   = stage_addr;
  assign bus.GrantId       = grant_id;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter against a behavioural
// model of the arbitration rules and of the register file contents.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 3;

  logic Clk;
  logic Rst_n;
  int   tests;
  int   fails;

  regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file fed by the DUT write port.
  logic [31:0] tb_rf [32] = '{default: 32'h0};
  always @(posedge Clk) if (bus.RegWrite) tb_rf[bus.WriteRegister] <= bus.WriteData;

  function automatic logic [31:0] rd(input int a);
    return (a == 0) ? 32'h0 : tb_rf[a];
  endfunction

  // Behavioural model state.
  bit          m_sv;
  int          m_addr;
  logic [31:0] m_data;
  int          m_gid;
  int          m_ptr;
  logic [31:0] m_rf [32];
  logic [N-1:0] last_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sv = 0; m_addr = 0; m_data = 0; m_gid = 0; m_ptr = 0;
  endtask

  // Inputs have just been driven at a negedge; check, then advance one cycle.
  task automatic step();
    int w;
    int start;
    logic [N-1:0] exp_ready;
    bit exp_rw;
    #1;
`ifdef REGARB_FIXED_PRIORITY_EN
    start = 0;
`else
    start = m_ptr;
`endif
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && bus.ReqValid[(start + k) % N]) w = (start + k) % N;
    exp_ready = (w >= 0 && !bus.Hold) ? N'(1 << w) : '0;
    exp_rw    = m_sv && !bus.Hold && (m_addr != 0);
    chk("ReqReady",      64'(bus.ReqReady),      64'(exp_ready));
    chk("RegWrite",      64'(bus.RegWrite),      64'(exp_rw));
    chk("PendingValid",  64'(bus.PendingValid),  64'(m_sv));
    chk("PendingAddr",   64'(bus.PendingAddr),   64'(m_addr));
    chk("WriteRegister", 64'(bus.WriteRegister), 64'(m_addr));
    chk("WriteData",     64'(bus.WriteData),     64'(m_data));
    chk("GrantId",       64'(bus.GrantId),       64'(m_gid));
    last_ready = exp_ready;
    @(posedge Clk);
    if (exp_rw) m_rf[m_addr] = m_data;
    if (exp_ready != '0) begin
      m_sv   = 1;
      m_addr = int'(bus.ReqAddr[w*AW +: AW]);
      m_data = bus.ReqData[w*DW +: DW];
      m_gid  = w;
      m_ptr  = (w + 1) % N;
    end else if (!bus.Hold) begin
      m_sv = 0;
    end
    @(negedge Clk);
  endtask

  task automatic set_req(input int i, input bit v, input int a, input logic [31:0] d);
    bus.ReqValid[i]        = v;
    bus.ReqAddr[i*AW +: AW] = AW'(a);
    bus.ReqData[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_RegWrite",     64'(bus.RegWrite),     64'(0));
    chk("rst_ReqReady",     64'(bus.ReqReady),     64'(0));
    chk("rst_PendingValid", 64'(bus.PendingValid), 64'(0));
    chk("rst_GrantId",      64'(bus.GrantId),      64'(0));
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend  [N];
    int          paddr [N];
    logic [31:0] pdata [N];
    tests = 0; fails = 0;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    bus.ReqValid = '0; bus.ReqAddr = '0; bus.ReqData = '0; bus.Hold = 1'b0;
    Rst_n = 1'b1;
    @(negedge Clk);

    // Reset with all requesters asking.
    bus.ReqValid = 3'b111;
    do_reset();
    bus.ReqValid = '0;

    // First write from requester 1.
    set_req(1, 1, 10, 32'h10);
    step();
    chk("first_ready", 64'(last_ready), 64'(3'b010));
    set_req(1, 0, 0, 0);
    #1;
    chk("first_RegWrite", 64'(bus.RegWrite), 64'(1));
    chk("first_WR",       64'(bus.WriteRegister), 64'(10));
    chk("first_WD",       64'(bus.WriteData), 64'(32'h10));
    chk("first_GrantId",  64'(bus.GrantId), 64'(1));
    step();
    step();

    // Round-robin fairness from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, i + 1, 32'h100 + i);
    for (int c = 0; c < 6; c++) begin
      step();
`ifdef REGARB_FIXED_PRIORITY_EN
      chk("rr_order", 64'(last_ready), 64'(3'b001));
`else
      chk("rr_order", 64'(last_ready), 64'(1 << (c % 3)));
`endif
      if (c > 0) chk("rr_RegWrite", 64'(bus.RegWrite), 64'(1));
      for (int i = 0; i < N; i++)
        if (last_ready[i]) set_req(i, 1, i + 1, 32'h200 + c * 16 + i);
    end
    bus.ReqValid = '0;
    step();
    step();

    // Hold freezes a pending write.
    set_req(0, 1, 14, 32'h111);
    step();
    set_req(0, 0, 0, 0);
    set_req(1, 1, 3, 32'h33);
    bus.Hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_PendingAddr", 64'(bus.PendingAddr), 64'(14));
    end
    bus.Hold = 1'b0;
    #1;
    chk("hold_release_RW", 64'(bus.RegWrite), 64'(1));
    chk("hold_release_WD", 64'(bus.WriteData), 64'(32'h111));
    step();
    set_req(1, 0, 0, 0);
    step();
    step();
    chk("hold_rf14", 64'(rd(14)), 64'(32'h111));

    // Register 0 write is absorbed.
    set_req(2, 1, 0, 32'hFFFF_FFFF);
    step();
    chk("r0_ready", 64'(last_ready), 64'(3'b100));
    set_req(2, 0, 0, 0);
    step();
    step();
    chk("r0_readback", 64'(rd(0)), 64'(0));

    // Same-address race: loser's data ends up in the register.
    do_reset();
    set_req(0, 1, 29, 32'hAA);
    set_req(1, 1, 29, 32'hBB);
    step();
    set_req(0, 0, 0, 0);
    step();
    set_req(1, 0, 0, 0);
    #1;
    chk("race_second_WD", 64'(bus.WriteData), 64'(32'hBB));
    step();
    step();
    chk("race_rf29", 64'(rd(29)), 64'(32'hBB));

    // Async reset while a write is staged.
    set_req(0, 1, 7, 32'h55);
    step();
    set_req(0, 0, 0, 0);
    step();
    set_req(0, 1, 7, 32'h777);
    step();
    set_req(0, 0, 0, 0);
    #1;
    chk("arst_RW_before", 64'(bus.RegWrite), 64'(1));
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_RW_after", 64'(bus.RegWrite), 64'(0));
    chk("arst_PV_after", 64'(bus.PendingValid), 64'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    step();
    chk("arst_rf7", 64'(rd(7)), 64'(32'h55));

    // Randomized traffic with stable-until-ready requesters.
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1;
          paddr[i] = int'($urandom_range(0, 31));
          pdata[i] = $urandom;
        end
        set_req(i, pend[i], pend[i] ? paddr[i] : 0, pend[i] ? pdata[i] : 32'h0);
      end
      bus.Hold = ($urandom_range(0, 3) == 0);
      step();
      for (int i = 0; i < N; i++) if (last_ready[i]) pend[i] = 0;
    end
    bus.ReqValid = '0;
    bus.Hold = 1'b0;
    step();
    step();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_%0d", r), 64'(rd(r)), 64'(r == 0 ? 32'h0 : m_rf[r]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file among NUM_REQ writeback sources, e.g. ALU writeback, load writeback and a debug/loader port. Each source uses a valid/ready handshake. A round-robin arbiter picks one source per cycle and loads it into a one-entry output stage. That stage drives WriteRegister, WriteData and RegWrite of the register file. The stage contents are also exported as a pending-write indication for decode hazard checks.

Parameters:
NUM_REQ, 3, number of write requesters (legal 2..8)
ADDR_W, 5, register address width
DATA_W, 32, write data width
ID_W, 3, width of GrantId; must be >= clog2(NUM_REQ)

Ports:
Clk  input  1  clock; all state on posedge
Rst_n  input  1  asynchronous active-low reset
ReqValid  input  NUM_REQ  bit i: requester i has a write
ReqAddr  input  NUM_REQ*ADDR_W  flattened; slice i = [i*ADDR_W +: ADDR_W]
ReqData  input  NUM_REQ*DATA_W  flattened; slice i = [i*DATA_W +: DATA_W]
ReqReady  output  NUM_REQ  one-hot or zero; handshake when ReqValid[i] & ReqReady[i]
Hold  input  1  freezes the write port (register file borrowed elsewhere)
WriteRegister  output  ADDR_W  to register file
WriteData  output  DATA_W  to register file
RegWrite  output  1  to register file write enable
PendingValid  output  1  stage holds a write not yet committed
PendingAddr  output  ADDR_W  address held in stage
GrantId  output  ID_W  index of requester whose write is in the stage

Behaviour:
- Reset (Rst_n low, async): StageValid=0, stage addr/data=0, GrantId=0, RR pointer=0. All outputs read 0 while in reset, including ReqReady.
- Stage can accept when Hold=0 and (StageValid=0 or the stage commits in this cycle). Since Hold=0 is required, the stage always drains when valid.
- Arbitration (combinational):
  - Search ReqValid starting at the RR pointer and wrap modulo NUM_REQ.
  - The first asserted index is the winner. ReqReady[winner]=1 only if the stage can accept; all other ReqReady bits are 0.
- On a handshake at posedge:
  - The stage loads the winner's addr/data and GrantId=winner, and sets StageValid=1.
  - RR pointer = (winner+1) mod NUM_REQ.
  - The pointer is unchanged on cycles with no handshake.
- No handshake with Hold=0: StageValid clears at posedge, so the stage is empty.
- Outputs:
  - RegWrite = StageValid & ~Hold & (stage addr != 0).
  - WriteRegister and WriteData = stage contents.
  - The register file commits at the next posedge.
- Latency: handshake at edge k; the register file is written at edge k+1, provided Hold=0 in that cycle.
- Throughput: one write per cycle with back-to-back handshakes.
- Hold=1:
  - RegWrite=0 and all ReqReady=0.
  - The stage, GrantId and RR pointer are retained.
  - The write is presented again when Hold falls.
- Register 0 writes: the handshake completes normally and the stage loads. RegWrite stays 0 for the whole stage lifetime, so the write is discarded. PendingValid still asserts.
- PendingValid=StageValid and PendingAddr=stage addr, including while Hold=1.
- Same address from two requesters in one cycle: the winner commits first and the loser commits on the next cycle. The final register value is the loser's data.
- Requesters must hold Valid/Addr/Data stable until Ready. If Valid drops before Ready, nothing is recorded and the pointer is unchanged.
- Reset mid-operation: a pending stage write is lost, and RegWrite falls immediately (async).
- The RR pointer never points outside 0..NUM_REQ-1.

Optional Feature:
Macro REGARB_FIXED_PRIORITY_EN.
- Defined: fixed priority. The lowest asserted index always wins; the RR pointer register is not implemented.
- Undefined: round-robin as described above.
- All other behaviour (stage, Hold, register 0, pending outputs) is identical in both modes.

Test Plan:
- Reset: Rst_n=0 with ReqValid=3'b111 -> RegWrite=0, ReqReady=0, PendingValid=0. Release, then ReqValid[1]=1 with addr 10, data 0x10 -> ReqReady=3'b010. Next cycle RegWrite=1, WriteRegister=10, WriteData=0x10, GrantId=1.
- Round-robin: ReqValid=3'b111 held 6 cycles with distinct data -> grant order 0,1,2,0,1,2. RegWrite stays 1 for 6 consecutive cycles, starting one cycle after the first grant. Under REGARB_FIXED_PRIORITY_EN the order is 0,0,0,0,0,0.
- Hold: a write is in the stage (addr 14, data 0x111), then Hold=1 for 3 cycles -> RegWrite=0, ReqReady=0, PendingValid=1, PendingAddr=14. Hold falls -> RegWrite=1 for one cycle with unchanged addr/data.
- Register 0: requester 2 writes addr 0, data 0xFFFFFFFF -> ReqReady[2] pulses, PendingValid=1 for one cycle, RegWrite stays 0. A readback of register 0 through the register file returns 0.
- Same-address race: requester 0 writes (29, 0xAA) and requester 1 writes (29, 0xBB) in the same cycle with pointer=0 -> commits 0xAA then 0xBB. Reading register 29 returns 0xBB.
- Async reset mid-write: assert Rst_n=0 between edges while StageValid=1 -> RegWrite falls before the next posedge, and register file contents are unchanged for that write.
